// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencing controller.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    RXC_OFF     = 2'd0,
    RXC_ARM     = 2'd1,
    RXC_LISTEN  = 2'd2,
    RXC_CAPTURE = 2'd3
  } rxc_state_e;

  localparam rxc_state_e             RXC_RST_STATE = RXC_OFF;
  localparam logic                   RXC_RST_RX_EN = 1'b0;
  localparam logic                   RXC_RST_FLAG  = 1'b0;
  localparam logic [UART_BYTE_W-1:0] RXC_RST_BYTE  = 8'h00;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign empty = (count_q == {CW{1'b0}});
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state pointers, occupancy and storage.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset clears storage so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: edge-qualifies receiver rdy, buffers bytes, flags overruns.
// Optional idle timeout is built when UART_RXC_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     rx_rdy,
  input  logic [UART_BYTE_W-1:0]   rx_data,
  output logic                     rx_en,
  output logic                     m_valid,
  output logic [UART_BYTE_W-1:0]   m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
`ifdef UART_RXC_TIMEOUT_EN
  output logic                     idle_timeout,
`endif
  input  logic                     clr_overrun
);

  rxc_state_e               state_q, state_d;
  logic                     rx_en_q, rx_en_d;
  logic                     overrun_q, overrun_d;
  logic [UART_BYTE_W-1:0]   byte_q, byte_d;
  logic                     push_s, drop_s, full_s, empty_s;

  rx_fifo #(.DEPTH(DEPTH), .W(UART_BYTE_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (m_ready),
    .din   (byte_q),
    .dout  (m_data),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  assign m_valid = !empty_s;
  assign rx_en   = rx_en_q;
  assign overrun = overrun_q;

  // Sequencer next state; dropping enable wins over every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RXC_OFF:     if (enable)  state_d = RXC_ARM;    else state_d = RXC_OFF;
      RXC_ARM:     if (!rx_rdy) state_d = RXC_LISTEN; else state_d = RXC_ARM;
      RXC_LISTEN:  if (rx_rdy)  state_d = RXC_CAPTURE; else state_d = RXC_LISTEN;
      RXC_CAPTURE: state_d = RXC_ARM;
      default:     state_d = RXC_OFF;
    endcase
    if (!enable) begin
      state_d = RXC_OFF;
    end else begin
      state_d = state_d;
    end
    rx_en_d = (state_d != RXC_OFF);
    if ((state_q == RXC_LISTEN) && rx_rdy && enable) begin
      byte_d = rx_data;
    end else begin
      byte_d = byte_q;
    end
    push_s = (state_q == RXC_CAPTURE) && enable;
    drop_s = push_s && full_s && !m_ready;
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Sequencer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RXC_RST_STATE;
      rx_en_q   <= RXC_RST_RX_EN;
      overrun_q <= RXC_RST_FLAG;
      byte_q    <= RXC_RST_BYTE;
    end else begin
      state_q   <= state_d;
      rx_en_q   <= rx_en_d;
      overrun_q <= overrun_d;
      byte_q    <= byte_d;
    end
  end

`ifdef UART_RXC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [TW-1:0] tmo_q, tmo_d;

  assign idle_timeout = (tmo_q >= TMO_MAX) && !empty_s;

  // Saturating count of cycles a non-empty FIFO has gone without a push.
  always_comb begin
    if ((push_s && !drop_s) || empty_s) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_q < TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= {TW{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed table-driven bench for uart_rx_ctrl (DEPTH=4), plus reset and timeout sequences.
module tb_uart_rx_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst, enable, rx_rdy, m_ready, clr_overrun;
  logic [7:0] rx_data;
  logic       rx_en, m_valid, overrun;
  logic [7:0] m_data;
  logic [2:0] count;
`ifdef UART_RXC_TIMEOUT_EN
  logic       idle_timeout;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_rdy       (rx_rdy),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .count        (count),
    .overrun      (overrun),
`ifdef UART_RXC_TIMEOUT_EN
    .idle_timeout (idle_timeout),
`endif
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, rdy;
    logic [7:0] data;
    logic       mr, clr;
    logic       xen, xmv;
    logic [7:0] xmd;
    logic [2:0] xcnt;
    logic       xov;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic en, input logic rdy, input logic [7:0] data,
                   input logic mr, input logic clr, input logic xen, input logic xmv,
                   input logic [7:0] xmd, input logic [2:0] xcnt, input logic xov);
    vec_t r;
    r.en = en; r.rdy = rdy; r.data = data; r.mr = mr; r.clr = clr;
    r.xen = xen; r.xmv = xmv; r.xmd = xmd; r.xcnt = xcnt; r.xov = xov;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stale ready rejected, then 1C captured two edges after it is seen
    v(H,H,8'hA5,L,L, H,L,8'h00,3'd0,L);
    v(H,H,8'hA5,L,L, H,L,8'h00,3'd0,L);
    v(H,L,8'h00,L,L, H,L,8'h00,3'd0,L);
    v(H,H,8'h1C,L,L, H,L,8'h00,3'd0,L);
    v(H,H,8'h1C,L,L, H,H,8'h1C,3'd1,L);
    v(H,H,8'h00,H,L, H,L,8'h00,3'd0,L);
    // fill with 01..05, fifth byte dropped
    v(H,L,8'h00,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h01,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h01,L,L, H,H,8'h01,3'd1,L);
    v(H,L,8'h00,L,L, H,H,8'h01,3'd1,L); v(H,H,8'h02,L,L, H,H,8'h01,3'd1,L); v(H,H,8'h02,L,L, H,H,8'h01,3'd2,L);
    v(H,L,8'h00,L,L, H,H,8'h01,3'd2,L); v(H,H,8'h03,L,L, H,H,8'h01,3'd2,L); v(H,H,8'h03,L,L, H,H,8'h01,3'd3,L);
    v(H,L,8'h00,L,L, H,H,8'h01,3'd3,L); v(H,H,8'h04,L,L, H,H,8'h01,3'd3,L); v(H,H,8'h04,L,L, H,H,8'h01,3'd4,L);
    v(H,L,8'h00,L,L, H,H,8'h01,3'd4,L); v(H,H,8'h05,L,L, H,H,8'h01,3'd4,L); v(H,H,8'h05,L,L, H,H,8'h01,3'd4,H);
    v(H,H,8'h00,H,L, H,H,8'h02,3'd3,H); v(H,H,8'h00,H,L, H,H,8'h03,3'd2,H);
    v(H,H,8'h00,H,L, H,H,8'h04,3'd1,H); v(H,H,8'h00,H,L, H,L,8'h00,3'd0,H);
    v(H,H,8'h00,L,H, H,L,8'h00,3'd0,L);
    // fill 11..14, then 15 pushed in the same cycle as a pop
    v(H,L,8'h00,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h11,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h11,L,L, H,H,8'h11,3'd1,L);
    v(H,L,8'h00,L,L, H,H,8'h11,3'd1,L); v(H,H,8'h12,L,L, H,H,8'h11,3'd1,L); v(H,H,8'h12,L,L, H,H,8'h11,3'd2,L);
    v(H,L,8'h00,L,L, H,H,8'h11,3'd2,L); v(H,H,8'h13,L,L, H,H,8'h11,3'd2,L); v(H,H,8'h13,L,L, H,H,8'h11,3'd3,L);
    v(H,L,8'h00,L,L, H,H,8'h11,3'd3,L); v(H,H,8'h14,L,L, H,H,8'h11,3'd3,L); v(H,H,8'h14,L,L, H,H,8'h11,3'd4,L);
    v(H,L,8'h00,L,L, H,H,8'h11,3'd4,L); v(H,H,8'h15,L,L, H,H,8'h11,3'd4,L); v(H,H,8'h15,H,L, H,H,8'h12,3'd4,L);
    v(H,H,8'h00,H,L, H,H,8'h13,3'd3,L); v(H,H,8'h00,H,L, H,H,8'h14,3'd2,L);
    v(H,H,8'h00,H,L, H,H,8'h15,3'd1,L); v(H,H,8'h00,H,L, H,L,8'h00,3'd0,L);
    // enable dropped while in CAPTURE: no push, rx_en low after the edge
    v(H,L,8'h00,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h77,L,L, H,L,8'h00,3'd0,L);
    v(L,H,8'h77,L,L, L,L,8'h00,3'd0,L); v(L,H,8'h77,L,L, L,L,8'h00,3'd0,L);
    // re-enable and load three bytes for the reset sequence
    v(H,H,8'h00,L,L, H,L,8'h00,3'd0,L);
    v(H,L,8'h00,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h21,L,L, H,L,8'h00,3'd0,L); v(H,H,8'h21,L,L, H,H,8'h21,3'd1,L);
    v(H,L,8'h00,L,L, H,H,8'h21,3'd1,L); v(H,H,8'h22,L,L, H,H,8'h21,3'd1,L); v(H,H,8'h22,L,L, H,H,8'h21,3'd2,L);
    v(H,L,8'h00,L,L, H,H,8'h21,3'd2,L); v(H,H,8'h23,L,L, H,H,8'h21,3'd2,L); v(H,H,8'h23,L,L, H,H,8'h21,3'd3,L);

    rst = 1'b1; enable = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clr_overrun = 1'b0;
    // reset held two cycles with rx_rdy toggling
    for (int i = 0; i < 2; i++) begin
      rx_rdy = ~rx_rdy;
      tick();
      chk("rst_rx_en", {7'd0, rx_en}, 8'h00);
      chk("rst_count", {5'd0, count}, 8'h00);
      chk("rst_m_valid", {7'd0, m_valid}, 8'h00);
      chk("rst_overrun", {7'd0, overrun}, 8'h00);
      chk("rst_m_data", m_data, 8'h00);
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; rx_rdy = vecs[i].rdy; rx_data = vecs[i].data;
      m_ready = vecs[i].mr; clr_overrun = vecs[i].clr;
      tick();
      chk($sformatf("v%0d_rx_en", i), {7'd0, rx_en}, {7'd0, vecs[i].xen});
      chk($sformatf("v%0d_m_valid", i), {7'd0, m_valid}, {7'd0, vecs[i].xmv});
      chk($sformatf("v%0d_count", i), {5'd0, count}, {5'd0, vecs[i].xcnt});
      chk($sformatf("v%0d_overrun", i), {7'd0, overrun}, {7'd0, vecs[i].xov});
      if (vecs[i].xmv) chk($sformatf("v%0d_m_data", i), m_data, vecs[i].xmd);
    end

    // mid-frame reset with three bytes buffered
    m_ready = 1'b0; clr_overrun = 1'b0; rx_rdy = 1'b0;
    tick();
    rx_rdy = 1'b1; rx_data = 8'h99; rst = 1'b1;
    tick();
    chk("midrst_count", {5'd0, count}, 8'h00);
    chk("midrst_m_valid", {7'd0, m_valid}, 8'h00);
    chk("midrst_rx_en", {7'd0, rx_en}, 8'h00);
    rst = 1'b0;
    tick();
    chk("postrst_rx_en", {7'd0, rx_en}, 8'h01);
    chk("postrst_count", {5'd0, count}, 8'h00);

`ifdef UART_RXC_TIMEOUT_EN
    // one byte sits unread: timeout asserts 16 edges after the push
    chk("tmo_idle", {7'd0, idle_timeout}, 8'h00);
    rx_rdy = 1'b0; tick();
    rx_rdy = 1'b1; rx_data = 8'h5A; tick();
    tick();
    chk("tmo_pushed", {5'd0, count}, 8'h01);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk($sformatf("tmo_c%0d", j), {7'd0, idle_timeout}, (j >= 16) ? 8'h01 : 8'h00);
    end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("tmo_after_pop", {7'd0, idle_timeout}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART `receiver` block. It owns the receiver's `en` input and edge-qualifies the level-style `rdy` output so each received byte is captured exactly once. Captured bytes are buffered in a small FIFO with a valid/ready consumer port, and the block flags overruns. It sits between the `receiver` instance and the bus/CPU side of the UART.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 16: idle cycles before `idle_timeout` asserts (only with `UART_RXC_TIMEOUT_EN`); ≥1.

- `clk`  in  1  single clock shared with `receiver`.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  software receive enable.
- `rx_rdy`  in  1  from `receiver.rdy`; high after a frame completes, low again at the next start bit.
- `rx_data`  in  8  from `receiver.data`; valid while `rx_rdy` is high.
- `rx_en`  out  1  to `receiver.en`.
- `m_valid`  out  1  FIFO non-empty.
- `m_data`  out  8  FIFO head byte; holds its value while `m_valid && !m_ready`.
- `m_ready`  in  1  consumer pops when `m_valid && m_ready`.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overrun`  out  1  sticky; a byte was dropped.
- `clr_overrun`  in  1  clears `overrun`.
- `idle_timeout`  out  1  only present with `UART_RXC_TIMEOUT_EN`.

## Operation
- States:
  - OFF: `rx_en`=0.
  - ARM: `rx_en`=1; waits for `rx_rdy`=0 so a stale frame is never captured.
  - LISTEN: `rx_en`=1; waits for `rx_rdy`=1.
  - CAPTURE: `rx_en`=1; one cycle; pushes the captured byte.
- Transitions:
  - OFF→ARM when `enable`=1.
  - ARM→LISTEN when `rx_rdy`=0.
  - LISTEN→CAPTURE when `rx_rdy`=1; `rx_data` is registered on this edge.
  - CAPTURE→ARM unconditionally.
  - Any state→OFF when `enable`=0. This takes priority, including mid-frame and in CAPTURE, where the pending push is abandoned.
- Push rule: accept if `count<DEPTH`, or if `count==DEPTH` and a pop occurs in the same cycle. Otherwise drop the byte and set `overrun`.
- Simultaneous push and pop: `count` is unchanged and the pointers both advance.
- Pop when empty is ignored.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` never exceeds DEPTH and never goes below 0.
- `overrun`:
  - Set has priority over `clr_overrun` in the same cycle.
  - Only `rst` or `clr_overrun` clears it.
- FIFO contents are retained across `enable` toggles. Only `rst` flushes them.

## Timing
- After `rst`:
  - State OFF.
  - `rx_en`=0, `m_valid`=0, `m_data`=0, `count`=0, `overrun`=0, `idle_timeout`=0.
  - Pointers are 0.
- `enable` rise at edge k: `rx_en`=1 after edge k.
- `rx_rdy` high sampled in LISTEN at edge k: push at edge k+1. With an empty FIFO, `m_valid`=1 and `m_data`=byte after edge k+1, giving 2 cycles of latency.
- Pop at edge k: the next head byte, or `m_valid`=0, is visible after edge k.
- `rst` mid-frame: all state returns to reset values on that edge. The receiver is disabled the following cycle via `rx_en`=0.
- `enable`=0 at edge k: `rx_en`=0 after edge k.

## Configuration
- `UART_RXC_TIMEOUT_EN` defined:
  - Adds the `idle_timeout` port and a saturating counter.
  - The counter resets on every push and whenever the FIFO is empty, and increments otherwise.
  - `idle_timeout`=1 while counter ≥ `TIMEOUT` and FIFO non-empty, so a partially filled FIFO is drained by the consumer.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `uart_pkg` holds:
  - the state enum (`RXC_OFF`, `RXC_ARM`, `RXC_LISTEN`, `RXC_CAPTURE`);
  - `UART_BYTE_W`=8;
  - reset constants for outputs.
- Sub-module `rx_fifo`: synchronous FIFO parameterized by DEPTH and width. Ports: push, pop, din, dout, count, full, empty. Push-when-full is allowed if pop occurs in the same cycle.
- The FSM, overrun logic and timeout counter live in `uart_rx_ctrl`.

## Test plan
- Reset and idle: hold `rst` 2 cycles with `enable`=0 and toggle `rx_rdy`. Required: `rx_en`=0, `count`=0, `m_valid`=0 throughout.
- Stale-ready rejection: `enable`=1 while `rx_rdy`=1 with `rx_data`=8'hA5. Required: no push. Then drive `rx_rdy` 0, then 1 with 8'h1C. Required: `m_data`=8'h1C exactly 2 cycles later, `count`=1.
- Fill and overrun: with `m_ready`=0, deliver bytes 8'h01..8'h05 with DEPTH=4. Required: `count`=4, `overrun`=1, pops return 01,02,03,04. Then `clr_overrun` → `overrun`=0.
- Full with simultaneous pop: FIFO full, 5th byte's push cycle has `m_ready`=1. Required: `count` stays 4, `overrun`=0, and the byte order is preserved across pointer wrap.
- Mid-operation disable/reset: drop `enable` in CAPTURE. Required: no push, `rx_en`=0 next cycle. Assert `rst` with `count`=3. Required: `count`=0, `m_valid`=0 after the edge.
- Timeout (macro on, TIMEOUT=16): push 1 byte with `m_ready`=0. Required: `idle_timeout`=1 from 16 cycles after the push, and 0 immediately after the pop empties the FIFO.
